// File: rtl/vxe_mem_hub_cu_ds_arb_pkg.sv
// Shared types and constants for the CU downstream response master-select arbiter.
package vxe_mem_hub_cu_ds_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Response status layout: {CID[8:3], RnW[2], Err[1:0]}
  localparam int RNW_BIT = 2;
  localparam int CID_MSB = 8;
  localparam int CID_LSB = 3;

  // Burst counter width covers MAX_BURST up to 255
  localparam int BURST_W = 8;

endpackage

// File: rtl/vxe_mem_hub_cu_ds_arb_pend.sv
// Signed pending-data-beat counter (read statuses minus data beats) with sticky range error.
module vxe_mem_hub_cu_ds_arb_pend #(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] pend_nx,
  output logic              err
);

  logic [PEND_W-1:0] pend;
  logic [PEND_W:0]   sum;
  logic              ovf;

  // One guard bit is enough: the counter moves by at most one per cycle
  always_comb begin
    sum     = {pend[PEND_W-1], pend} + {{PEND_W{1'b0}}, inc} - {{PEND_W{1'b0}}, dec};
    ovf     = sum[PEND_W] ^ sum[PEND_W-1];
    pend_nx = ovf ? pend : sum[PEND_W-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_nx;
      err  <= err | ovf;
    end
  end

endmodule

// File: rtl/vxe_mem_hub_cu_ds_arb.sv
// Round-robin master select for the CU downstream response mux; switches only at response boundaries.
// Optional per-master/switch statistics counters: define VXE_MEM_HUB_CU_DS_ARB_STATS_EN.
module vxe_mem_hub_cu_ds_arb
  import vxe_mem_hub_cu_ds_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int PEND_W    = 4
) (
  input  logic        clk,
  input  logic        nrst,
`ifdef VXE_MEM_HUB_CU_DS_ARB_STATS_EN
  output logic [31:0] o_m0_cnt,
  output logic [31:0] o_m1_cnt,
  output logic [15:0] o_sw_cnt,
`endif
  output logic        o_m_sel,
  output logic        o_busy,
  output logic        o_err,
  input  logic        i_m0_rss_vld,
  input  logic        i_m0_rss_rnw,
  input  logic        i_m0_rss_rd,
  input  logic        i_m0_rsd_vld,
  input  logic        i_m0_rsd_rd,
  input  logic        i_m1_rss_vld,
  input  logic        i_m1_rss_rnw,
  input  logic        i_m1_rss_rd,
  input  logic        i_m1_rsd_vld,
  input  logic        i_m1_rsd_rd
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state, state_nx;
  logic               sel, prio;
  logic [BURST_W-1:0] burst, burst_nx;
  logic               s_hs, d_hs, rnw_sel, vld_sel, vld_oth, bnd;
  logic               tog, to_idle;
  logic [PEND_W-1:0]  pend_nx;

  // Only the selected master's handshakes count; the mux gates the other one off
  always_comb begin
    s_hs     = sel ? (i_m1_rss_vld & i_m1_rss_rd) : (i_m0_rss_vld & i_m0_rss_rd);
    d_hs     = sel ? (i_m1_rsd_vld & i_m1_rsd_rd) : (i_m0_rsd_vld & i_m0_rsd_rd);
    rnw_sel  = sel ? i_m1_rss_rnw : i_m0_rss_rnw;
    vld_sel  = sel ? i_m1_rss_vld : i_m0_rss_vld;
    vld_oth  = sel ? i_m0_rss_vld : i_m1_rss_vld;
    burst_nx = (burst >= BURST_MAX) ? burst : burst + {{(BURST_W-1){1'b0}}, s_hs};
    bnd      = (pend_nx == '0);
  end

  vxe_mem_hub_cu_ds_arb_pend #(.PEND_W(PEND_W)) u_pend (
    .clk     (clk),
    .nrst    (nrst),
    .inc     (s_hs & rnw_sel),
    .dec     (d_hs),
    .pend_nx (pend_nx),
    .err     (o_err)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tog      = 1'b0;
    to_idle  = 1'b0;
    case (state)
      IDLE: begin
        if (vld_sel && vld_oth) begin
          if (prio == sel) begin
            state_nx = BUSY;
          end else if (bnd) begin
            state_nx = BUSY;
            tog      = 1'b1;
          end
        end else if (vld_sel) begin
          state_nx = BUSY;
        end else if (vld_oth && bnd) begin
          state_nx = BUSY;
          tog      = 1'b1;
        end
      end
      BUSY: begin
        // Burst limit only forces a switch when the other master is waiting
        if (bnd && vld_oth && (!vld_sel || burst_nx >= BURST_MAX)) begin
          tog = 1'b1;
        end else if (bnd && !vld_sel && !vld_oth) begin
          state_nx = IDLE;
          to_idle  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state == BUSY);
    o_m_sel = sel;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sel   <= 1'b0;
      prio  <= 1'b1;
      burst <= '0;
    end else begin
      sel   <= sel ^ tog;
      burst <= (tog || to_idle) ? '0 : burst_nx;
      if (state == BUSY && tog) prio <= sel;
      else if (to_idle)         prio <= ~sel;
    end
  end

`ifdef VXE_MEM_HUB_CU_DS_ARB_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_m0_cnt <= '0;
      o_m1_cnt <= '0;
      o_sw_cnt <= '0;
    end else begin
      if (s_hs && !sel) o_m0_cnt <= o_m0_cnt + 32'd1;
      if (s_hs &&  sel) o_m1_cnt <= o_m1_cnt + 32'd1;
      if (tog)          o_sw_cnt <= o_sw_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vxe_mem_hub_cu_ds_arb.sv
// Scoreboard bench: expected master order of consumed statuses plus directed select/err checks.
module tb_vxe_mem_hub_cu_ds_arb;

  logic clk, nrst;
  logic o_m_sel, o_busy, o_err;
  logic m0_rss_vld, m0_rss_rnw, m0_rss_rd, m0_rsd_vld, m0_rsd_rd;
  logic m1_rss_vld, m1_rss_rnw, m1_rss_rd, m1_rsd_vld, m1_rsd_rd;
`ifdef VXE_MEM_HUB_CU_DS_ARB_STATS_EN
  logic [31:0] m0_cnt, m1_cnt;
  logic [15:0] sw_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int busy_cyc;
  bit sq0[$];
  bit sq1[$];
  int exp_q[$];

  vxe_mem_hub_cu_ds_arb #(.MAX_BURST(8), .PEND_W(4)) dut (
    .clk          (clk),
    .nrst         (nrst),
`ifdef VXE_MEM_HUB_CU_DS_ARB_STATS_EN
    .o_m0_cnt     (m0_cnt),
    .o_m1_cnt     (m1_cnt),
    .o_sw_cnt     (sw_cnt),
`endif
    .o_m_sel      (o_m_sel),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .i_m0_rss_vld (m0_rss_vld),
    .i_m0_rss_rnw (m0_rss_rnw),
    .i_m0_rss_rd  (m0_rss_rd),
    .i_m0_rsd_vld (m0_rsd_vld),
    .i_m0_rsd_rd  (m0_rsd_rd),
    .i_m1_rss_vld (m1_rss_vld),
    .i_m1_rss_rnw (m1_rss_rnw),
    .i_m1_rss_rd  (m1_rss_rd),
    .i_m1_rsd_vld (m1_rsd_vld),
    .i_m1_rsd_rd  (m1_rsd_rd)
  );

  // Downstream mux model: consumes whatever the granted master offers while a grant is active
  assign m0_rss_rd = o_busy & ~o_m_sel & m0_rss_vld;
  assign m0_rsd_rd = o_busy & ~o_m_sel & m0_rsd_vld;
  assign m1_rss_rd = o_busy &  o_m_sel & m1_rss_vld;
  assign m1_rsd_rd = o_busy &  o_m_sel & m1_rsd_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    m0_rss_vld = (sq0.size() > 0);
    m0_rss_rnw = (sq0.size() > 0) ? sq0[0] : 1'b0;
    m1_rss_vld = (sq1.size() > 0);
    m1_rss_rnw = (sq1.size() > 0) ? sq1[0] : 1'b0;
  endtask

  task automatic push(input int m, input bit rnw, input int n);
    for (int i = 0; i < n; i++) begin
      if (m == 0) sq0.push_back(rnw);
      else        sq1.push_back(rnw);
    end
    drive();
  endtask

  task automatic expect_m(input int m, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(m);
  endtask

  task automatic step();
    logic h0, h1, d0, d1;
    int e;
    @(negedge clk);
    h0 = m0_rss_vld & m0_rss_rd;
    h1 = m1_rss_vld & m1_rss_rd;
    d0 = m0_rsd_vld & m0_rsd_rd;
    d1 = m1_rsd_vld & m1_rsd_rd;
    if (o_busy) busy_cyc++;
    if (h0 && h1) chk("sb_dual_hs", 1, 0);
    else if (h0 || h1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_hs", int'(h1), -1);
      else begin
        e = exp_q.pop_front();
        chk("sb_master", int'(h1), e);
      end
    end
    @(posedge clk);
    #1;
    if (h0) void'(sq0.pop_front());
    if (h1) void'(sq1.pop_front());
    if (d0) m0_rsd_vld = 1'b0;
    if (d1) m1_rsd_vld = 1'b0;
    drive();
  endtask

  task automatic clear_stim();
    sq0.delete();
    sq1.delete();
    exp_q.delete();
    m0_rsd_vld = 1'b0;
    m1_rsd_vld = 1'b0;
    drive();
  endtask

  initial begin
    nrst = 1'b0;
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", int'(o_m_sel), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_err", int'(o_err), 0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Three writes from M0 alone: four busy cycles, then idle on M0
    busy_cyc = 0;
    expect_m(0, 3);
    push(0, 1'b0, 3);
    repeat (6) step();
    chk("wr3_busy_cycles", busy_cyc, 4);
    chk("wr3_busy_end", int'(o_busy), 0);
    chk("wr3_sel", int'(o_m_sel), 0);
    chk("wr3_err", int'(o_err), 0);

    // M0 read, data three cycles later while M1 waits: select holds until the data beat
    expect_m(0, 1);
    expect_m(1, 1);
    push(0, 1'b1, 1);
    step();
    step();
    push(1, 1'b0, 1);
    chk("rd_lat_sel_t1", int'(o_m_sel), 0);
    step();
    chk("rd_lat_sel_t2", int'(o_m_sel), 0);
    step();
    m0_rsd_vld = 1'b1;
    chk("rd_lat_sel_t3", int'(o_m_sel), 0);
    step();
    chk("rd_lat_sel_t4", int'(o_m_sel), 1);
    repeat (3) step();
    chk("rd_lat_idle", int'(o_busy), 0);
    chk("rd_lat_err", int'(o_err), 0);

    // Both masters saturated with writes: grants alternate every 8 statuses
    expect_m(0, 8);
    expect_m(1, 8);
    expect_m(0, 8);
    expect_m(1, 8);
    push(0, 1'b0, 16);
    push(1, 1'b0, 16);
    repeat (40) step();
    chk("burst_idle", int'(o_busy), 0);
    chk("burst_sel", int'(o_m_sel), 1);
    chk("burst_sb_left", exp_q.size(), 0);

    // Reset clears the priority pointer: both valid afterwards grants M1 first
    nrst = 1'b0;
    clear_stim();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    expect_m(1, 2);
    expect_m(0, 2);
    push(0, 1'b0, 2);
    push(1, 1'b0, 2);
    step();
    chk("tie_first_sel", int'(o_m_sel), 1);
    repeat (6) step();
    chk("tie_end_sel", int'(o_m_sel), 0);
    chk("tie_idle", int'(o_busy), 0);

    // M1 data beat ahead of its read status: no switch while pend is -1
    expect_m(1, 2);
    expect_m(0, 1);
    push(1, 1'b0, 1);
    m1_rsd_vld = 1'b1;
    step();
    push(0, 1'b0, 1);
    step();
    chk("early_data_sel_c2", int'(o_m_sel), 1);
    step();
    chk("early_data_sel_c3", int'(o_m_sel), 1);
    push(1, 1'b1, 1);
    step();
    chk("early_data_sel_c4", int'(o_m_sel), 1);
    step();
    chk("early_data_sel_c5", int'(o_m_sel), 0);
    repeat (4) step();
    chk("early_data_idle", int'(o_busy), 0);
    chk("early_data_err", int'(o_err), 0);
    chk("early_data_sb_left", exp_q.size(), 0);

    // Reads without data on M1: counter overflows on the 8th, error sticks, reset clears all
    expect_m(1, 10);
    push(1, 1'b1, 10);
    repeat (8) step();
    chk("ovf_err_after7", int'(o_err), 0);
    step();
    chk("ovf_err_after8", int'(o_err), 1);
    step();
    chk("ovf_err_sticky", int'(o_err), 1);
    chk("ovf_busy", int'(o_busy), 1);
    chk("ovf_sel", int'(o_m_sel), 1);
    chk("ovf_sb_left", exp_q.size(), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_sel", int'(o_m_sel), 0);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_err", int'(o_err), 0);
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_err", int'(o_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vxe_mem_hub_cu_ds_arb.md
Name: vxe_mem_hub_cu_ds_arb

Overview:
- Generates the master-select for the CU downstream response path. The path muxes two master response streams (status + data) into one CU response port.
- Watches valid signals and consumed handshakes on both masters. Grants one master at a time in round-robin order.
- Changes the select only at a response boundary, so a read status and its data beat always come from the same master.
- Bounds each grant with a burst limit for fairness.

Parameters:
- MAX_BURST, 8, maximum response statuses consumed per grant before a forced switch (when the other master waits); range 1..255.
- PEND_W, 4, width of the signed counter of pending data beats (read statuses consumed minus data beats consumed).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- o_m_sel  out  1  master select to the downstream path (0 = Master 0, 1 = Master 1)
- o_busy  out  1  a grant is active (state BUSY)
- o_err  out  1  sticky pending-counter overflow/underflow error
- i_m0_rss_vld  in  1  Master 0 response status valid
- i_m0_rss_rnw  in  1  Master 0 status RnW bit (status bit [2]; status layout {CID[8:3], RnW[2], Err[1:0]})
- i_m0_rss_rd  in  1  Master 0 status read strobe, as driven by the downstream path
- i_m0_rsd_vld  in  1  Master 0 response data valid
- i_m0_rsd_rd  in  1  Master 0 data read strobe, as driven by the downstream path
- i_m1_rss_vld, i_m1_rss_rnw, i_m1_rss_rd, i_m1_rsd_vld, i_m1_rsd_rd  in  1 each  same signals for Master 1

Behaviour:
- Reset values: o_m_sel=0, o_busy=0, o_err=0, state=IDLE, pend=0, burst=0, prio pointer=1 (Master 1 wins the first tie).
- Handshakes, evaluated every cycle in every state, sel = current o_m_sel:
  - s_hs = rss_vld[sel] & rss_rd[sel]
  - d_hs = rsd_vld[sel] & rsd_rd[sel]
  - Handshakes on the non-selected master are ignored; the downstream path gates them off.
- Pending counter:
  - pend_nx = pend + (s_hs & rss_rnw[sel]) - d_hs
  - A read status always carries exactly one data beat, including error responses; a write status carries none.
  - Data may arrive before its status, so pend may go negative.
  - If pend_nx leaves the signed PEND_W range: hold pend at its current value, set o_err; o_err stays set until reset.
- Burst counter: burst_nx = burst + s_hs, saturating at MAX_BURST.
- Boundary: bnd = (pend_nx==0).
- IDLE:
  - Only the selected master has rss_vld: keep sel -> BUSY.
  - Only the other master has rss_vld and bnd: toggle sel -> BUSY.
  - Both valid: grant the prio master; toggle sel if that differs from the current sel -> BUSY.
  - Neither valid: stay.
- BUSY: o_busy=1.
  - Switch when bnd & rss_vld[~sel] & (!rss_vld[sel] | burst_nx>=MAX_BURST).
  - On switch: sel toggles at this clock edge, burst=0, prio=old sel, stay in BUSY.
  - Idle exit when bnd & !rss_vld[0] & !rss_vld[1]: -> IDLE, burst=0, prio=~sel.
  - Otherwise stay.
- Switch latency: the decision is registered, so o_m_sel changes at the edge after the last handshake; the first handshake on the new master can occur in the next cycle.
- A handshake in the same cycle as a switch decision is counted against the old master.
- Never switch while bnd=0, even if the burst limit is reached. The burst limit applies only when the other master is waiting.
- Reset mid-operation: all state returns to reset values immediately; outstanding beats are forgotten.

Optional Feature:
- VXE_MEM_HUB_CU_DS_ARB_STATS_EN defined:
  - Adds outputs o_m0_cnt[31:0], o_m1_cnt[31:0], reset 0.
  - Each counts consumed statuses per master and wraps at 2^32.
  - Adds o_sw_cnt[15:0], the number of grant switches, wrapping.
- Not defined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=1'b0, BUSY=1'b1), status bit position constants (RNW_BIT=2, CID_MSB=8, CID_LSB=3).
- One sub-module: vxe_mem_hub_cu_ds_arb_pend, the signed pending-beat counter with overflow detect, instantiated once.
- Arbiter FSM and burst/prio logic stay in the top.

Test Plan:
- M0 issues 3 writes, M1 idle -> o_m_sel stays 0, o_busy high for the burst, then IDLE; pend stays 0, o_err=0.
- M0 read: status in cycle t, data in t+3, M1 rss_vld high from t+1 -> o_m_sel stays 0 until the data handshake at t+3, goes to 1 at t+4.
- Both masters continuously valid with writes, MAX_BURST=8 -> grants alternate after exactly 8 statuses each; o_m_sel toggles every 8 status handshakes.
- Data beat before status on M1 (pend=-1), then status -> pend returns to 0; switch is allowed only after the status.
- Both valid from reset -> first grant is M1 (o_m_sel=1 one cycle after the valids); after M1 drains, M0 is granted.
- Force 8 read statuses with no data, PEND_W=4 -> o_err set on the 8th, sticky; assert nrst mid-burst -> all outputs 0 asynchronously.
